// File: rtl/sm4_key_expand_seq_pkg.sv
// Shared definitions for the SM4 key-schedule block.
// Holds the FK system parameters, the controller state type, the width and
// round-count constants, and the CK constant generator used by every round.
package sm4_key_expand_seq_pkg;

    localparam int ROUNDS = 32;
    localparam int KEY_W  = 128;
    localparam int WORD_W = 32;

    // FK0 sits in the top word so it lines up with MK0 = key_in[127:96].
    localparam logic [KEY_W-1:0] FK = {32'hA3B1BAC6, 32'h56AA3350,
                                       32'h677D9197, 32'hB27022DC};

    typedef enum logic [1:0] {
        IDLE,
        EXPAND,
        DONE
    } state_t;

    // CK_i byte j (j=0 is the MSB) = ((4i+j)*7) mod 256.
    // 4i+j is just {i, j[1:0]}, so each byte is one small constant multiply.
    function automatic logic [WORD_W-1:0] ck_word(input logic [4:0] i);
        logic [WORD_W-1:0] w;
        logic [9:0]        p;
        w = '0;
        for (int j = 0; j < 4; j++) begin
            p = {3'b000, i, 2'(j)} * 10'd7;
            w[(3-j)*8 +: 8] = p[7:0];
        end
        return w;
    endfunction

endpackage

// File: rtl/sm4_key_expand_seq_if.sv
// Bus between a key source / round-key consumer (master) and the SM4 key
// expander (slave).
//   key_valid/key_in/key_ready : master key handshake (MK0 in key_in[127:96])
//   keys_valid/busy            : expansion status
//   rk_rd_en/dec/addr/data     : round-key read port, data registered
interface sm4_key_expand_seq_if;
    logic         key_valid;
    logic [127:0] key_in;
    logic         key_ready;
    logic         keys_valid;
    logic         busy;
    logic         rk_rd_en;
    logic         rk_rd_dec;
    logic [4:0]   rk_rd_addr;
    logic [31:0]  rk_rd_data;

    modport master (
        output key_valid, key_in, rk_rd_en, rk_rd_dec, rk_rd_addr,
        input  key_ready, keys_valid, busy, rk_rd_data
    );

    modport slave (
        input  key_valid, key_in, rk_rd_en, rk_rd_dec, rk_rd_addr,
        output key_ready, keys_valid, busy, rk_rd_data
    );
endinterface

// File: rtl/sm4_key_expand_seq_round.sv
// One combinational SM4 key-schedule round.
//   k0..k3 : current key window K_i .. K_{i+3}
//   rnd    : round index i (selects CK_i)
//   rk     : new word K_{i+4} = rk_i = K_i ^ T'(K_{i+1}^K_{i+2}^K_{i+3}^CK_i)
module sm4_key_round
    import sm4_key_expand_seq_pkg::*;
(
    input  logic [WORD_W-1:0] k0,
    input  logic [WORD_W-1:0] k1,
    input  logic [WORD_W-1:0] k2,
    input  logic [WORD_W-1:0] k3,
    input  logic [4:0]        rnd,
    output logic [WORD_W-1:0] rk
);

    logic [WORD_W-1:0] x;
    logic [WORD_W-1:0] b;

    assign x = k1 ^ k2 ^ k3 ^ ck_word(rnd);

    for (genvar n = 0; n < 4; n++) begin : g_sbox
        sm4_sbox u_sbox (
            .din  (x[8*n +: 8]),
            .dout (b[8*n +: 8])
        );
    end

    // L'(B) = B ^ (B <<< 13) ^ (B <<< 23)
    assign rk = k0 ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};

endmodule

// File: rtl/sm4_sbox.sv
// SM4 S-box byte substitution, purely combinational.
//   din  : input byte
//   dout : substituted byte
module sm4_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);

    // Entry 0 is the leftmost byte (ascending packed range).
    localparam logic [0:255][7:0] SBOX = {
        128'hd690e9fecce13db716b614c228fb2c05,
        128'h2b679a762abe04c3aa44132649860699,
        128'h9c4250f491ef987a33540b43edcfac62,
        128'he4b31ca9c908e89580df94fa758f3fa6,
        128'h4707a7fcf37317ba83593c19e6854fa8,
        128'h686b81b27164da8bf8eb0f4b70569d35,
        128'h1e240e5e6358d1a225227c3b01217887,
        128'hd40046579fd327524c3602e7a0c4c89e,
        128'heabf8ad240c738b5a3f7f2cef96115a1,
        128'he0ae5da49b341a55ad933230f58cb1e3,
        128'h1df6e22e8266ca60c02923ab0d534e6f,
        128'hd5db3745defd8e2f03ff6a726d6c5b51,
        128'h8d1baf92bbddbc7f11d95c411f105ad8,
        128'h0ac13188a5cd7bbd2d74d012b8e5b4b0,
        128'h8969974a0c96777e65b9f109c56ec684,
        128'h18f07dec3adc4d2079ee5f3ed7cb3948
    };

    assign dout = SBOX[din];

endmodule

// File: rtl/sm4_key_expand_seq.sv
// Sequential SM4 key expansion with a 32-entry round-key store.
// Accepts a 128-bit master key, runs RPC rounds per clock for 32/RPC cycles,
// then exposes the round keys through a registered read port that can walk
// them in encryption or decryption order.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sm4_key_expand_seq_if slave (key handshake, status, read port)
module sm4_key_expand_seq
    import sm4_key_expand_seq_pkg::*;
#(
    parameter int RPC = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    sm4_key_expand_seq_if.slave  bus
);

    if (!(RPC == 1 || RPC == 2 || RPC == 4 || RPC == 8)) begin : g_bad_rpc
        $error("sm4_key_expand_seq: RPC must be 1, 2, 4 or 8");
    end

    localparam logic [4:0] LAST_CNT = 5'(ROUNDS - RPC);
    localparam logic [4:0] CNT_STEP = 5'(RPC);

    state_t state, state_nxt;

    logic key_ready, keys_valid, busy;
    logic accept;

    logic [3:0][WORD_W-1:0]   kwin;       // kwin[0] = K_i (oldest word)
    logic [3:0][WORD_W-1:0]   kwin_nxt;
    logic [4:0]               cnt;        // index of first round this cycle
    logic [RPC-1:0][WORD_W-1:0] rk_new;
    logic [KEY_W-1:0]         kx;
    logic [WORD_W-1:0]        rd_data;
    logic [4:0]               rd_idx;

    // Round-key store; deliberately not reset.
    logic [WORD_W-1:0] rk_mem [ROUNDS];

    assign accept = bus.key_valid && key_ready;
    assign kx     = bus.key_in ^ FK;

    // ---- FSM: state register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // ---- FSM: next state ----
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = EXPAND;
            EXPAND:  if (cnt == LAST_CNT) state_nxt = DONE;
            DONE:    if (accept) state_nxt = EXPAND;
            default: state_nxt = IDLE;
        endcase
    end

    // ---- FSM: outputs ----
    always_comb begin
        key_ready  = 1'b1;
        busy       = 1'b0;
        keys_valid = 1'b0;
        case (state)
            EXPAND: begin
                key_ready = 1'b0;
                busy      = 1'b1;
            end
            DONE:    keys_valid = 1'b1;
            default: ;
        endcase
    end

    assign bus.key_ready  = key_ready;
    assign bus.busy       = busy;
    assign bus.keys_valid = keys_valid;

    // ---- round chain: each stage shifts the window by one word ----
    for (genvar j = 0; j < RPC; j++) begin : g_rnd
        logic [3:0][WORD_W-1:0] w_cur;
        logic [3:0][WORD_W-1:0] w_nxt;
        logic [WORD_W-1:0]      rk_j;

        if (j == 0) begin : g_first
            assign w_cur = kwin;
        end else begin : g_next
            assign w_cur = g_rnd[j-1].w_nxt;
        end

        sm4_key_round u_round (
            .k0  (w_cur[0]),
            .k1  (w_cur[1]),
            .k2  (w_cur[2]),
            .k3  (w_cur[3]),
            .rnd (cnt + 5'(j)),
            .rk  (rk_j)
        );

        assign w_nxt     = {rk_j, w_cur[3], w_cur[2], w_cur[1]};
        assign rk_new[j] = rk_j;
    end

    assign kwin_nxt = g_rnd[RPC-1].w_nxt;

    // Reads are 5-bit indices, so 31-addr is simply the bitwise inverse.
    assign rd_idx = bus.rk_rd_dec ? ~bus.rk_rd_addr : bus.rk_rd_addr;

    // ---- datapath registers ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            kwin    <= '0;
            cnt     <= '0;
            rd_data <= '0;
        end else begin
            if (accept) begin
                for (int w = 0; w < 4; w++)
                    kwin[w] <= kx[KEY_W-1-WORD_W*w -: WORD_W];
                cnt <= '0;
            end else if (state == EXPAND) begin
                kwin <= kwin_nxt;
                cnt  <= cnt + CNT_STEP;
            end
            // Storage is read before this edge's writes land, so a read
            // alongside an accept or a round write sees the old contents.
            if (bus.rk_rd_en)
                rd_data <= rk_mem[rd_idx];
        end
    end

    always_ff @(posedge clk) begin
        if (state == EXPAND) begin
            for (int j = 0; j < RPC; j++)
                rk_mem[cnt + 5'(j)] <= rk_new[j];
        end
    end

    assign bus.rk_rd_data = rd_data;

endmodule

// File: tb/tb_sm4_key_expand_seq.sv
module tb_sm4_key_expand_seq;

    localparam logic [127:0] MK_A  = 128'h0123456789ABCDEFFEDCBA9876543210;
    localparam logic [31:0]  A_RK0  = 32'hF12186F9;
    localparam logic [31:0]  A_RK31 = 32'h9124A012;
    localparam logic [31:0]  Z_RK0  = 32'h45603B23;   // rk0 for MK = 0

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic [2:0]   kv = '0;
    logic [127:0] key_in = '0;
    logic         rd_en = 1'b0;
    logic         rd_dec = 1'b0;
    logic [4:0]   rd_addr = '0;

    sm4_key_expand_seq_if bus1 ();
    sm4_key_expand_seq_if bus4 ();
    sm4_key_expand_seq_if bus8 ();

    assign bus1.key_valid = kv[0];
    assign bus4.key_valid = kv[1];
    assign bus8.key_valid = kv[2];
    assign bus1.key_in = key_in;
    assign bus4.key_in = key_in;
    assign bus8.key_in = key_in;
    assign bus1.rk_rd_en = rd_en;
    assign bus4.rk_rd_en = rd_en;
    assign bus8.rk_rd_en = rd_en;
    assign bus1.rk_rd_dec = rd_dec;
    assign bus4.rk_rd_dec = rd_dec;
    assign bus8.rk_rd_dec = rd_dec;
    assign bus1.rk_rd_addr = rd_addr;
    assign bus4.rk_rd_addr = rd_addr;
    assign bus8.rk_rd_addr = rd_addr;

    sm4_key_expand_seq #(.RPC(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
    sm4_key_expand_seq #(.RPC(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus4));
    sm4_key_expand_seq #(.RPC(8)) u_dut8 (.clk(clk), .rst(rst), .bus(bus8));

    logic [2:0]  kvld, kbusy, krdy;
    logic [31:0] rdd [3];
    assign kvld  = {bus8.keys_valid, bus4.keys_valid, bus1.keys_valid};
    assign kbusy = {bus8.busy, bus4.busy, bus1.busy};
    assign krdy  = {bus8.key_ready, bus4.key_ready, bus1.key_ready};
    assign rdd[0] = bus1.rk_rd_data;
    assign rdd[1] = bus4.rk_rd_data;
    assign rdd[2] = bus8.rk_rd_data;

    int tests = 0;
    int fails = 0;
    int done_cyc [3];
    int busy_cyc [3];
    bit rdy_bad [3];

    function automatic int rpc_of(input int d);
        return (d == 0) ? 1 : (d == 1) ? 4 : 8;
    endfunction

    task automatic accept_key(input logic [127:0] k);
        @(negedge clk);
        kv = 3'b111;
        key_in = k;
        tests++;
        if (krdy !== 3'b111) begin
            fails++;
            $display("FAIL accept_ready: key_ready=%b want 111", krdy);
        end
        @(posedge clk);
        #1 kv = '0;
    endtask

    // Call right after the accept edge; cycle 1 is the first EXPAND cycle.
    task automatic wait_done(input bit hold);
        for (int d = 0; d < 3; d++) begin
            done_cyc[d] = -1;
            busy_cyc[d] = 0;
            rdy_bad[d]  = 1'b0;
        end
        for (int n = 1; n <= 80; n++) begin
            @(negedge clk);
            for (int d = 0; d < 3; d++) begin
                if (kbusy[d]) begin
                    busy_cyc[d]++;
                    if (krdy[d] !== 1'b0) rdy_bad[d] = 1'b1;
                end
                if (kvld[d] && done_cyc[d] < 0) begin
                    done_cyc[d] = n;
                    if (hold) kv[d] = 1'b0;
                end
            end
            if (done_cyc[0] > 0 && done_cyc[1] > 0 && done_cyc[2] > 0) break;
        end
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (done_cyc[d] != 32 / rpc_of(d) + 1) begin
                fails++;
                $display("FAIL done_latency rpc=%0d: got cycle %0d want %0d",
                         rpc_of(d), done_cyc[d], 32 / rpc_of(d) + 1);
            end
            tests++;
            if (busy_cyc[d] != 32 / rpc_of(d)) begin
                fails++;
                $display("FAIL busy_cycles rpc=%0d: got %0d want %0d",
                         rpc_of(d), busy_cyc[d], 32 / rpc_of(d));
            end
            tests++;
            if (rdy_bad[d]) begin
                fails++;
                $display("FAIL ready_in_expand rpc=%0d: key_ready seen 1 want 0", rpc_of(d));
            end
        end
        kv = '0;
    endtask

    task automatic do_read(input logic dec, input logic [4:0] a);
        @(negedge clk);
        rd_en = 1'b1;
        rd_dec = dec;
        rd_addr = a;
        @(posedge clk);
        #1 rd_en = 1'b0;
    endtask

    task automatic check_rd(input string nm, input logic [31:0] exp);
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (rdd[d] !== exp) begin
                fails++;
                $display("FAIL %s rpc=%0d: got %h want %h", nm, rpc_of(d), rdd[d], exp);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        rd_en = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            tests++;
            if (krdy[d] !== 1'b1 || kvld[d] !== 1'b0 || kbusy[d] !== 1'b0) begin
                fails++;
                $display("FAIL reset_status rpc=%0d: rdy=%b vld=%b busy=%b want 1 0 0",
                         rpc_of(d), krdy[d], kvld[d], kbusy[d]);
            end
        end
        check_rd("reset_rd_data", 32'h0);
        @(negedge clk);
        rd_en = 1'b0;
        rst = 1'b0;
    endtask

    task automatic test_expand();
        accept_key(MK_A);
        wait_done(1'b0);
    endtask

    task automatic test_read();
        do_read(1'b0, 5'd0);
        check_rd("enc_addr0", A_RK0);
        do_read(1'b1, 5'd0);
        check_rd("dec_addr0", A_RK31);
        do_read(1'b1, 5'd31);
        check_rd("dec_addr31", A_RK0);
        do_read(1'b0, 5'd31);
        check_rd("enc_addr31", A_RK31);
        // rd_en low: data must hold even though the address now points elsewhere
        @(negedge clk);
        rd_addr = 5'd0;
        rd_dec = 1'b0;
        @(posedge clk);
        #1 check_rd("rd_hold", A_RK31);
    endtask

    task automatic test_rpc_match();
        logic [31:0] r1;
        for (int a = 0; a < 32; a++) begin
            do_read(1'b0, 5'(a));
            r1 = rdd[0];
            for (int d = 1; d < 3; d++) begin
                tests++;
                if (rdd[d] !== r1) begin
                    fails++;
                    $display("FAIL rpc_match addr=%0d rpc=%0d: got %h want %h",
                             a, rpc_of(d), rdd[d], r1);
                end
            end
        end
    endtask

    task automatic test_mk0_from_done();
        accept_key('0);
        tests++;
        if (kvld !== 3'b000 || kbusy !== 3'b111) begin
            fails++;
            $display("FAIL redo_drop: keys_valid=%b busy=%b want 000 111", kvld, kbusy);
        end
        wait_done(1'b0);
        do_read(1'b0, 5'd0);
        check_rd("mk0_rk0", Z_RK0);
        do_read(1'b1, 5'd31);
        check_rd("mk0_dec31", Z_RK0);
    endtask

    task automatic test_ignore_during_expand();
        @(negedge clk);
        kv = 3'b111;
        key_in = MK_A;
        @(posedge clk);
        #1 key_in = '0;              // a different key stays offered
        wait_done(1'b1);
        @(negedge clk);
        tests++;
        if (kbusy !== 3'b000 || kvld !== 3'b111) begin
            fails++;
            $display("FAIL ignore_no_restart: busy=%b keys_valid=%b want 000 111", kbusy, kvld);
        end
        do_read(1'b0, 5'd0);
        check_rd("ignore_rk0", A_RK0);
        do_read(1'b0, 5'd31);
        check_rd("ignore_rk31", A_RK31);
    endtask

    task automatic test_reset_mid_expand();
        accept_key('0);
        repeat (9) @(negedge clk);
        @(negedge clk);              // 10th EXPAND cycle
        rst = 1'b1;
        #1;
        tests++;
        if (kvld !== 3'b000 || kbusy !== 3'b000 || krdy !== 3'b111) begin
            fails++;
            $display("FAIL mid_reset: vld=%b busy=%b rdy=%b want 000 000 111", kvld, kbusy, krdy);
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        tests++;
        if (kvld !== 3'b000 || kbusy !== 3'b000) begin
            fails++;
            $display("FAIL post_reset_idle: vld=%b busy=%b want 000 000", kvld, kbusy);
        end
        accept_key(MK_A);
        wait_done(1'b0);
        do_read(1'b0, 5'd0);
        check_rd("after_rst_rk0", A_RK0);
        do_read(1'b0, 5'd31);
        check_rd("after_rst_rk31", A_RK31);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_expand();
        test_read();
        test_rpc_match();
        test_mk0_from_done();
        test_ignore_during_expand();
        test_reset_mid_expand();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
